// File: rtl/if_stage.sv
// Instruction fetch stage: drives an SRAM-like fetch port with at most one request
// outstanding, holds the fetched instruction until ID accepts it, and handles branch
// redirects, flush redirects and misaligned-PC (AdEL) fetches.

package if_stage_pkg;

  typedef struct packed {
    logic        br_op;
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic ex;
    logic eret;
  } pipeline_flush_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic        bd;
    logic [31:0] badvaddr;
    logic        tlb_refill;
  } fs_exception_t;

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc;
    logic [31:0]   inst;
    fs_exception_t exception;
  } fs_to_ds_bus_t;

endpackage

module if_stage
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ds_allowin,
  input  logic            br_bus_en,
  input  br_bus_t         br_bus,
  input  pipeline_flush_t pipeline_flush,
  input  logic [31:0]     flush_target,
  output fs_to_ds_bus_t   fs_to_ds_bus,
  output logic            inst_req,
  output logic [31:0]     inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [31:0]     inst_rdata
);

  localparam logic [31:0] ResetPc = 32'hBFC0_0000;
  localparam logic [4:0]  ExcAdel = 5'h04;

  typedef enum logic [1:0] {StReq, StWait, StHold} fs_state_e;

  fs_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fs_valid_q, fs_valid_d;
  logic        cancel_q, cancel_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;
  logic        br_op_q, br_op_d;
  logic [31:0] inst_q, inst_d;
  logic        adel_q, adel_d;
  // Flush seen in REQ before addr_ok: the handshake must finish with the old address.
  logic        flush_pend_q, flush_pend_d;
  logic [31:0] flush_pc_q, flush_pc_d;

  logic        flush;
  logic        req_fire;
  logic        br_take;
  logic        fast_valid;
  logic        hold_valid;
  logic        out_valid;
  logic        handoff;
  logic        bd_out;
  logic [31:0] next_pc;
  logic [31:0] redirect_pc;
  logic        unused_stall;

  assign flush        = pipeline_flush.ex | pipeline_flush.eret;
  assign req_fire     = (state_q == StReq) && (pc_q[1:0] == 2'b00);
  assign br_take      = br_bus_en & br_bus.taken;
  assign fast_valid   = (state_q == StWait) & inst_data_ok & ~cancel_q & ~flush;
  assign hold_valid   = (state_q == StHold) & fs_valid_q & ~flush;
  assign out_valid    = fast_valid | hold_valid;
  assign handoff      = out_valid & ds_allowin;
  assign redirect_pc  = flush ? flush_target : flush_pc_q;
  assign unused_stall = br_bus.stall;

  // A branch reported in the same cycle as the delay-slot handoff is taken directly.
  assign next_pc = br_take      ? br_bus.target :
                   br_pending_q ? br_target_q   : pc_q + 32'd4;
  assign bd_out  = br_bus_en ? br_bus.br_op : br_op_q;

  assign inst_req  = req_fire & ~reset;
  assign inst_addr = inst_req ? pc_q : 32'h0;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StReq;
      pc_q         <= ResetPc;
      fs_valid_q   <= 1'b0;
      cancel_q     <= 1'b0;
      br_pending_q <= 1'b0;
      br_target_q  <= 32'h0;
      br_op_q      <= 1'b0;
      inst_q       <= 32'h0;
      adel_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_pc_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fs_valid_q   <= fs_valid_d;
      cancel_q     <= cancel_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
      br_op_q      <= br_op_d;
      inst_q       <= inst_d;
      adel_q       <= adel_d;
      flush_pend_q <= flush_pend_d;
      flush_pc_q   <= flush_pc_d;
    end
  end

  // Next-state logic: fetch FSM, redirects and branch bookkeeping.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fs_valid_d   = fs_valid_q;
    cancel_d     = cancel_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    br_op_d      = br_op_q;
    inst_d       = inst_q;
    adel_d       = adel_q;
    flush_pend_d = flush_pend_q;
    flush_pc_d   = flush_pc_q;

    unique case (state_q)
      StReq: begin
        if (req_fire) begin
          if (flush_pend_q || flush) begin
            if (inst_addr_ok) begin
              // Request already accepted; its data must be dropped.
              state_d      = StWait;
              cancel_d     = 1'b1;
              pc_d         = redirect_pc;
              flush_pend_d = 1'b0;
            end else begin
              flush_pend_d = 1'b1;
              flush_pc_d   = redirect_pc;
            end
          end else if (inst_addr_ok) begin
            state_d = StWait;
          end
        end else if (flush) begin
          pc_d = flush_target;
        end else begin
          // Misaligned PC: no request, deliver an AdEL pseudo-instruction.
          state_d    = StHold;
          fs_valid_d = 1'b1;
          inst_d     = 32'h0;
          adel_d     = 1'b1;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
          if (flush || cancel_q) begin
            state_d  = StReq;
            cancel_d = 1'b0;
            if (flush) pc_d = flush_target;
          end else if (ds_allowin) begin
            state_d = StReq;
            pc_d    = next_pc;
          end else begin
            state_d    = StHold;
            fs_valid_d = 1'b1;
            inst_d     = inst_rdata;
            adel_d     = 1'b0;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
          pc_d     = flush_target;
        end
      end
      StHold: begin
        if (flush) begin
          state_d    = StReq;
          fs_valid_d = 1'b0;
          adel_d     = 1'b0;
          pc_d       = flush_target;
        end else if (ds_allowin) begin
          state_d    = StReq;
          fs_valid_d = 1'b0;
          adel_d     = 1'b0;
          pc_d       = next_pc;
        end
      end
      default: begin
        state_d = StReq;
      end
    endcase

    if (flush) begin
      br_pending_d = 1'b0;
      br_op_d      = 1'b0;
    end else if (handoff) begin
      br_pending_d = 1'b0;
      br_op_d      = 1'b0;
    end else begin
      if (br_take) begin
        br_pending_d = 1'b1;
        br_target_d  = br_bus.target;
      end
      if (br_bus_en) br_op_d = br_bus.br_op;
    end
  end

  // Output bus; all fields are zero whenever nothing valid is presented.
  always_comb begin
    fs_to_ds_bus = '0;
    if (out_valid) begin
      fs_to_ds_bus.valid                = 1'b1;
      fs_to_ds_bus.pc                   = pc_q;
      fs_to_ds_bus.inst                 = fast_valid ? inst_rdata : inst_q;
      fs_to_ds_bus.exception.ex         = hold_valid & adel_q;
      fs_to_ds_bus.exception.exccode    = (hold_valid & adel_q) ? ExcAdel : 5'h00;
      fs_to_ds_bus.exception.bd         = bd_out;
      fs_to_ds_bus.exception.badvaddr   = (hold_valid & adel_q) ? pc_q : 32'h0;
      fs_to_ds_bus.exception.tlb_refill = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a behavioural fetch memory plus a scoreboard of
// expected ID handoffs, checked as each handoff happens.

module tb_if_stage;
  import if_stage_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            ds_allowin;
  logic            br_bus_en;
  br_bus_t         br_bus;
  pipeline_flush_t pipeline_flush;
  logic [31:0]     flush_target;
  fs_to_ds_bus_t   fs_to_ds_bus;
  logic            inst_req;
  logic [31:0]     inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [31:0]     inst_rdata;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_bus_en      (br_bus_en),
    .br_bus         (br_bus),
    .pipeline_flush (pipeline_flush),
    .flush_target   (flush_target),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic        bd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          checks = 0;
  int          errors = 0;
  int          hcount = 0;

  // Memory model state.
  bit          m_pend;
  logic [31:0] m_addr;
  int          m_cnt;
  int          data_lat;
  bit          addr_gate;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  task automatic drive_mem();
    inst_addr_ok = inst_req && !m_pend && addr_gate;
    inst_data_ok = m_pend && (m_cnt == 0);
    inst_rdata   = inst_data_ok ? mem_word(m_addr) : 32'hDEAD_BEEF;
    #1;
  endtask

  // One clock: drive memory, score any handoff, log accepted requests, advance.
  task automatic step();
    exp_t        e;
    logic [4:0]  exp_code;
    logic [31:0] exp_bad;
    bit          acc;
    logic [31:0] acc_addr;
    drive_mem();
    if (fs_to_ds_bus.valid && ds_allowin) begin
      checks++;
      hcount++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL handoff_unexpected: got pc=%h inst=%h, required no handoff",
                 fs_to_ds_bus.pc, fs_to_ds_bus.inst);
      end else begin
        e        = exp_q.pop_front();
        exp_code = e.ex ? 5'h04 : 5'h00;
        exp_bad  = e.ex ? e.pc : 32'h0;
        if (fs_to_ds_bus.pc !== e.pc || fs_to_ds_bus.inst !== e.inst ||
            fs_to_ds_bus.exception.ex !== e.ex || fs_to_ds_bus.exception.exccode !== exp_code ||
            fs_to_ds_bus.exception.bd !== e.bd || fs_to_ds_bus.exception.badvaddr !== exp_bad ||
            fs_to_ds_bus.exception.tlb_refill !== 1'b0) begin
          errors++;
          $display("FAIL handoff: got pc=%h inst=%h ex=%b code=%h bd=%b bad=%h, required pc=%h inst=%h ex=%b code=%h bd=%b bad=%h",
                   fs_to_ds_bus.pc, fs_to_ds_bus.inst, fs_to_ds_bus.exception.ex,
                   fs_to_ds_bus.exception.exccode, fs_to_ds_bus.exception.bd,
                   fs_to_ds_bus.exception.badvaddr, e.pc, e.inst, e.ex, exp_code, e.bd, exp_bad);
        end
      end
    end
    acc      = inst_req && inst_addr_ok;
    acc_addr = inst_addr;
    if (acc) req_log.push_back(acc_addr);
    @(posedge clk);
    if (inst_data_ok) m_pend = 1'b0;
    else if (m_pend && m_cnt > 0) m_cnt--;
    if (acc) begin
      m_pend = 1'b1;
      m_addr = acc_addr;
      m_cnt  = data_lat;
    end
    @(negedge clk);
  endtask

  task automatic run_handoffs(input int k, input int bound);
    for (int i = 0; i < bound && hcount < k; i++) step();
    checks++;
    if (hcount < k) begin
      errors++;
      $display("FAIL handoff_timeout: got %0d handoffs, required %0d", hcount, k);
    end
  endtask

  task automatic run_reqs(input int k, input int bound);
    for (int i = 0; i < bound && req_log.size() < k; i++) step();
    checks++;
    if (req_log.size() < k) begin
      errors++;
      $display("FAIL req_timeout: got %0d requests, required %0d", req_log.size(), k);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    ds_allowin     = 1'b0;
    br_bus_en      = 1'b0;
    br_bus         = '0;
    pipeline_flush = '0;
    flush_target   = 32'h0;
    addr_gate      = 1'b1;
    data_lat       = 0;
    m_pend         = 1'b0;
    m_cnt          = 0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = 32'h0;
    exp_q.delete();
    req_log.delete();
    hcount = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (inst_req !== 1'b0 || fs_to_ds_bus !== '0) begin
      errors++;
      $display("FAIL reset_hold: got req=%b bus_valid=%b, required req=0 bus=0",
               inst_req, fs_to_ds_bus.valid);
    end
    do_reset();
    drive_mem();
    checks++;
    if (inst_req !== 1'b1) begin
      errors++;
      $display("FAIL first_req: got %b, required 1", inst_req);
    end
    checks++;
    if (inst_addr !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL first_addr: got %h, required bfc00000", inst_addr);
    end
    step();
    // Reset in WAIT: outstanding request abandoned, memory reset too.
    reset  = 1'b1;
    m_pend = 1'b0;
    #1;
    checks++;
    if (inst_req !== 1'b0 || fs_to_ds_bus !== '0) begin
      errors++;
      $display("FAIL reset_async: got req=%b bus_valid=%b, required req=0 bus=0",
               inst_req, fs_to_ds_bus.valid);
    end
    @(negedge clk);
    drive_mem();
    checks++;
    if (inst_req !== 1'b0 || fs_to_ds_bus.valid !== 1'b0 || dut.pc_q !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL reset_mid: got req=%b valid=%b pc=%h, required req=0 valid=0 pc=bfc00000",
               inst_req, fs_to_ds_bus.valid, dut.pc_q);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_reqs [3];
    exp_reqs[0] = 32'hBFC0_0000;
    exp_reqs[1] = 32'hBFC0_0004;
    exp_reqs[2] = 32'hBFC0_0008;
    do_reset();
    ds_allowin = 1'b1;
    exp_q.push_back('{32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0});
    exp_q.push_back('{32'hBFC0_0004, mem_word(32'hBFC0_0004), 1'b0, 1'b0});
    run_reqs(3, 30);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== exp_reqs[i]) begin
        errors++;
        $display("FAIL basic_req%0d: got %h, required %h", i,
                 (req_log.size() > i) ? req_log[i] : 32'hX, exp_reqs[i]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      drive_mem();
      checks++;
      if (fs_to_ds_bus.valid !== 1'b1 || fs_to_ds_bus.pc !== 32'hBFC0_0000 ||
          fs_to_ds_bus.inst !== 32'h2408_0001 || inst_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b pc=%h inst=%h req=%b, required 1 bfc00000 24080001 0",
                 i, fs_to_ds_bus.valid, fs_to_ds_bus.pc, fs_to_ds_bus.inst, inst_req);
      end
      step();
    end
    ds_allowin = 1'b1;
    exp_q.push_back('{32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0});
    run_handoffs(1, 10);
    run_reqs(2, 10);
    checks++;
    if (req_log.size() < 2 || req_log[1] !== 32'hBFC0_0004) begin
      errors++;
      $display("FAIL stall_next_req: got %h, required bfc00004",
               (req_log.size() > 1) ? req_log[1] : 32'hX);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ds_allowin = 1'b1;
    exp_q.push_back('{32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0});
    exp_q.push_back('{32'hBFC0_0004, mem_word(32'hBFC0_0004), 1'b0, 1'b0});
    exp_q.push_back('{32'hBFC0_0008, mem_word(32'hBFC0_0008), 1'b0, 1'b0});
    exp_q.push_back('{32'hBFC0_000C, mem_word(32'hBFC0_000C), 1'b0, 1'b1});
    exp_q.push_back('{32'hBFC0_0100, mem_word(32'hBFC0_0100), 1'b0, 1'b0});
    run_handoffs(3, 30);
    // Branch at 0x08 now sits in ID.
    br_bus_en = 1'b1;
    br_bus    = '{br_op: 1'b1, stall: 1'b0, taken: 1'b1, target: 32'hBFC0_0100};
    step();
    br_bus_en = 1'b0;
    br_bus    = '0;
    run_handoffs(5, 30);
    checks++;
    if (req_log.size() < 5 || req_log[4] !== 32'hBFC0_0100) begin
      errors++;
      $display("FAIL branch_target_req: got %h, required bfc00100",
               (req_log.size() > 4) ? req_log[4] : 32'hX);
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    ds_allowin = 1'b1;
    data_lat   = 2;
    exp_q.push_back('{32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0});
    run_handoffs(1, 20);
    step();
    pipeline_flush = '{ex: 1'b1, eret: 1'b0};
    flush_target   = 32'hBFC0_0380;
    step();
    pipeline_flush = '0;
    exp_q.push_back('{32'hBFC0_0380, mem_word(32'hBFC0_0380), 1'b0, 1'b0});
    run_handoffs(2, 40);
    checks++;
    if (req_log.size() != 3 || req_log[1] !== 32'hBFC0_0004 || req_log[2] !== 32'hBFC0_0380) begin
      errors++;
      $display("FAIL flush_wait_reqs: got %0d reqs last=%h, required 3 reqs last=bfc00380",
               req_log.size(), (req_log.size() > 0) ? req_log[req_log.size()-1] : 32'hX);
    end
  endtask

  task automatic test_flush_req_noaddr();
    do_reset();
    addr_gate      = 1'b0;
    pipeline_flush = '{ex: 1'b0, eret: 1'b1};
    flush_target   = 32'hBFC0_0380;
    step();
    pipeline_flush = '0;
    for (int i = 0; i < 2; i++) begin
      drive_mem();
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000) begin
        errors++;
        $display("FAIL noaddr_stable%0d: got req=%b addr=%h, required 1 bfc00000",
                 i, inst_req, inst_addr);
      end
      step();
    end
    addr_gate  = 1'b1;
    ds_allowin = 1'b1;
    exp_q.push_back('{32'hBFC0_0380, mem_word(32'hBFC0_0380), 1'b0, 1'b0});
    run_handoffs(1, 20);
    checks++;
    if (req_log.size() != 2 || req_log[0] !== 32'hBFC0_0000 || req_log[1] !== 32'hBFC0_0380) begin
      errors++;
      $display("FAIL noaddr_reqs: got %0d reqs, required bfc00000 then bfc00380", req_log.size());
    end
  endtask

  task automatic test_adel();
    do_reset();
    pipeline_flush = '{ex: 1'b1, eret: 1'b0};
    flush_target   = 32'hBFC0_0382;
    step();
    pipeline_flush = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      drive_mem();
      checks++;
      if (inst_req !== 1'b0) begin
        errors++;
        $display("FAIL adel_no_req%0d: got %b, required 0", i, inst_req);
      end
    end
    ds_allowin = 1'b1;
    exp_q.push_back('{32'hBFC0_0382, 32'h0, 1'b1, 1'b0});
    run_handoffs(1, 10);
    checks++;
    if (req_log.size() != 1 || req_log[0] !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL adel_reqs: got %0d reqs, required 1", req_log.size());
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    ds_allowin = 1'b1;
    exp_q.push_back('{32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0});
    run_handoffs(1, 20);
    br_bus_en      = 1'b1;
    br_bus         = '{br_op: 1'b1, stall: 1'b0, taken: 1'b1, target: 32'hBFC0_0100};
    pipeline_flush = '{ex: 1'b1, eret: 1'b0};
    flush_target   = 32'hBFC0_0380;
    step();
    br_bus_en      = 1'b0;
    br_bus         = '0;
    pipeline_flush = '0;
    checks++;
    if (dut.br_pending_q !== 1'b0) begin
      errors++;
      $display("FAIL brflush_pending: got %b, required 0", dut.br_pending_q);
    end
    exp_q.push_back('{32'hBFC0_0380, mem_word(32'hBFC0_0380), 1'b0, 1'b0});
    run_handoffs(2, 30);
    run_reqs(4, 10);
    checks++;
    if (req_log.size() < 4 || req_log[2] !== 32'hBFC0_0380 || req_log[3] !== 32'hBFC0_0384) begin
      errors++;
      $display("FAIL brflush_reqs: got %h %h, required bfc00380 bfc00384",
               (req_log.size() > 2) ? req_log[2] : 32'hX, (req_log.size() > 3) ? req_log[3] : 32'hX);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_flush_wait();
    test_flush_req_noaddr();
    test_adel();
    test_branch_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
